// File: rtl/bpu_pkg.sv
// Shared definitions for the branch prediction unit: 2-bit counter encodings,
// the BTB entry layout and the counter value every BHT slot resets to.
// Pure declarations; no logic, no latency, no flow control.
package bpu_pkg;

  // 2-bit saturating direction counter; MSB set means "predict taken"
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_ctr_e;

  // Every BHT slot starts weakly not-taken so one taken outcome flips it
  localparam bht_ctr_e BHT_RST_VAL = WNT;

  // BTB entry layout at the default widths ({valid, tag, target}); the unit
  // declares the same layout sized by its own TAG_W/ADDR_W parameters
  localparam int BTB_TAG_W  = 8;
  localparam int BTB_ADDR_W = 32;

  typedef struct packed {
    logic                  valid;
    logic [BTB_TAG_W-1:0]  tag;
    logic [BTB_ADDR_W-1:0] target;
  } btb_entry_t;

  // Direction implied by a counter value
  function automatic logic ctr_predicts_taken(input logic [1:0] ctr);
    return ctr[1];
  endfunction

endpackage

// File: rtl/bht_sat_ctr.sv
// Next-state logic of one 2-bit saturating branch-history counter.
// Purely combinational, zero latency.
// No flow control; the caller decides whether the new value is written.
module bht_sat_ctr
  import bpu_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  output logic [1:0] nxt
);

  // Step toward the observed outcome, holding at the SNT/ST rails
  always_comb begin
    nxt = cur;
    if (taken) begin
      if (cur != ST) nxt = cur + 2'd1;
    end else begin
      if (cur != SNT) nxt = cur - 2'd1;
    end
  end

endmodule

// File: rtl/branch_pred_unit.sv
// Branch prediction unit: direct-mapped BTB plus 2-bit BHT, resolved-branch update.
// Lookup is combinational (0 cycles); updates and preloads land on the next rising edge.
// No backpressure: one lookup, one update and one preload are accepted every cycle.
// Optional macro BPU_GSHARE_EN: BHT indexed by pc index XOR global history (gshare).
module branch_pred_unit
  import bpu_pkg::*;
#(
  parameter  int ADDR_W  = 32,
  parameter  int ENTRIES = 256,
  parameter  int TAG_W   = 8,
  parameter  int GHR_W   = 8,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       lookup_pc,
  output logic                    pred_hit,
  output logic                    pred_taken,
  output logic [ADDR_W-1:0]       pred_target,
  input  logic                    upd_valid,
  input  logic [ADDR_W-1:0]       upd_pc,
  input  logic [ADDR_W-1:0]       upd_target,
  input  logic                    upd_is_branch,
  input  logic                    upd_taken,
  input  logic                    upd_pred_taken,
  input  logic [ADDR_W-1:0]       upd_pred_target,
  output logic                    mispredict,
  output logic [ADDR_W-1:0]       redirect_pc,
  input  logic                    init_we,
  input  logic [IDX_W-1:0]        init_idx,
  input  logic [TAG_W+ADDR_W:0]   init_btb,
  input  logic [1:0]              init_bht,
  output logic [31:0]             perf_branches,
  output logic [31:0]             perf_mispredicts
);

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
  } btb_ent_t;

  // Tables: BTB split into valid/tag/target so only the valid bits need reset
  logic              btb_vld [ENTRIES];
  logic [TAG_W-1:0]  btb_tag [ENTRIES];
  logic [ADDR_W-1:0] btb_tgt [ENTRIES];
  logic [1:0]        bht     [ENTRIES];
  logic [GHR_W-1:0]  ghr;

  logic [IDX_W-1:0]  lk_btb_idx, lk_bht_idx, up_btb_idx, up_bht_idx;
  logic [TAG_W-1:0]  lk_tag, up_tag;
  logic [1:0]        bht_nxt;
  logic              btb_upd_en, bht_upd_en, hist_upd_en;
  logic [GHR_W-1:0]  ghr_nxt;
  btb_ent_t          init_ent;

  // Word-offset and upper PC bits do not take part in indexing or tagging
  logic              unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc, upd_pc};

  assign init_ent   = init_btb;

  assign lk_btb_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag     = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign up_btb_idx = upd_pc[IDX_W+1:2];
  assign up_tag     = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  // History is committed only at resolution, so lookup and update hash with the same GHR
`ifdef BPU_GSHARE_EN
  assign lk_bht_idx = lk_btb_idx ^ IDX_W'(ghr);
  assign up_bht_idx = up_btb_idx ^ IDX_W'(ghr);
`else
  assign lk_bht_idx = lk_btb_idx;
  assign up_bht_idx = up_btb_idx;
`endif

  // Lookup reads the tables as they stand before the coming edge
  assign pred_hit    = btb_vld[lk_btb_idx] && (btb_tag[lk_btb_idx] == lk_tag);
  assign pred_taken  = pred_hit && ctr_predicts_taken(bht[lk_bht_idx]);
  assign pred_target = pred_hit ? btb_tgt[lk_btb_idx] : '0;

  // Resolution: wrong direction, or taken to a different target than predicted
  assign mispredict  = upd_valid &&
                       ((upd_taken != upd_pred_taken) ||
                        (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = upd_taken ? upd_target : (upd_pc + ADDR_W'(4));

  bht_sat_ctr u_ctr (
    .cur   (bht[up_bht_idx]),
    .taken (upd_taken),
    .nxt   (bht_nxt)
  );

  // A preload to the same slot wins over the resolved-branch update
  assign btb_upd_en  = upd_valid && upd_taken &&
                       !(init_we && (init_idx == up_btb_idx));
  assign bht_upd_en  = upd_valid && upd_is_branch &&
                       !(init_we && (init_idx == up_bht_idx));
  assign hist_upd_en = upd_valid && upd_is_branch;
  assign ghr_nxt     = GHR_W'({ghr, upd_taken});

  // BTB valid bits and BHT counters: reset, resolved-branch update, then preload
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_vld[i] <= 1'b0;
        bht[i]     <= BHT_RST_VAL;
      end
    end else begin
      if (btb_upd_en) btb_vld[up_btb_idx] <= 1'b1;
      if (bht_upd_en) bht[up_bht_idx]     <= bht_nxt;
      if (init_we) begin
        btb_vld[init_idx] <= init_ent.valid;
        bht[init_idx]     <= init_bht;
      end
    end
  end

  // BTB tag/target payload; meaningless until its valid bit is set, so no reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (btb_upd_en) begin
        btb_tag[up_btb_idx] <= up_tag;
        btb_tgt[up_btb_idx] <= upd_target;
      end
      if (init_we) begin
        btb_tag[init_idx] <= init_ent.tag;
        btb_tgt[init_idx] <= init_ent.target;
      end
    end
  end

  // Global history and saturating statistics counters
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr              <= '0;
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (hist_upd_en) ghr <= ghr_nxt;
      if (upd_valid && (perf_branches != 32'hFFFF_FFFF))
        perf_branches <= perf_branches + 32'd1;
      if (mispredict && (perf_mispredicts != 32'hFFFF_FFFF))
        perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_pred_unit.sv
// Self-checking bench for branch_pred_unit: directed steps, then random traffic
// compared against a table-level reference model kept here.
// Inputs change after the falling edge; outputs are compared before the rising edge.
module tb_branch_pred_unit;

  localparam int ADDR_W = 32;
  localparam int ENT    = 256;
  localparam int IDX_W  = 8;
  localparam int TAG_W  = 8;
  localparam int GHR_W  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [ADDR_W-1:0]     lookup_pc;
  logic                  pred_hit, pred_taken;
  logic [ADDR_W-1:0]     pred_target;
  logic                  upd_valid, upd_is_branch, upd_taken, upd_pred_taken;
  logic [ADDR_W-1:0]     upd_pc, upd_target, upd_pred_target;
  logic                  mispredict;
  logic [ADDR_W-1:0]     redirect_pc;
  logic                  init_we;
  logic [IDX_W-1:0]      init_idx;
  logic [TAG_W+ADDR_W:0] init_btb;
  logic [1:0]            init_bht;
  logic [31:0]           perf_branches, perf_mispredicts;

  branch_pred_unit #(
    .ADDR_W(ADDR_W), .ENTRIES(ENT), .TAG_W(TAG_W), .GHR_W(GHR_W)
  ) dut (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_is_branch(upd_is_branch), .upd_taken(upd_taken),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .init_we(init_we), .init_idx(init_idx), .init_btb(init_btb), .init_bht(init_bht),
    .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: plain arrays of integers, updated from the rules directly
  int          m_vld [ENT];
  int          m_tag [ENT];
  logic [31:0] m_tgt [ENT];
  int          m_ctr [ENT];
  logic [31:0] m_ghr, m_pb, m_pm;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bidx(input logic [31:0] pc);
    return int'((pc >> 2) % ENT);
  endfunction

  function automatic int tagof(input logic [31:0] pc);
    return int'((pc >> (2 + IDX_W)) % (1 << TAG_W));
  endfunction

  function automatic int hidx(input logic [31:0] pc);
`ifdef BPU_GSHARE_EN
    return int'(((pc >> 2) ^ m_ghr) % ENT);
`else
    return int'((pc >> 2) % ENT);
`endif
  endfunction

  task automatic model_update(input logic misp);
    int ub, uh;
    if (rst) begin
      for (int i = 0; i < ENT; i++) begin
        m_vld[i] = 0;
        m_ctr[i] = 1;
      end
      m_ghr = 0; m_pb = 0; m_pm = 0;
    end else begin
      ub = bidx(upd_pc);
      uh = hidx(upd_pc);
      if (upd_valid && upd_is_branch && !(init_we && int'(init_idx) == uh))
        m_ctr[uh] = upd_taken ? ((m_ctr[uh] == 3) ? 3 : m_ctr[uh] + 1)
                              : ((m_ctr[uh] == 0) ? 0 : m_ctr[uh] - 1);
      if (upd_valid && upd_taken && !(init_we && int'(init_idx) == ub)) begin
        m_vld[ub] = 1;
        m_tag[ub] = tagof(upd_pc);
        m_tgt[ub] = upd_target;
      end
      if (init_we) begin
        m_vld[init_idx] = int'(init_btb[TAG_W+ADDR_W]);
        m_tag[init_idx] = int'(init_btb[TAG_W+ADDR_W-1:ADDR_W]);
        m_tgt[init_idx] = init_btb[ADDR_W-1:0];
        m_ctr[init_idx] = int'(init_bht);
      end
      if (upd_valid && upd_is_branch) m_ghr = ((m_ghr << 1) | 32'(upd_taken)) % (1 << GHR_W);
      if (upd_valid && m_pb != 32'hFFFF_FFFF) m_pb = m_pb + 1;
      if (misp && m_pm != 32'hFFFF_FFFF) m_pm = m_pm + 1;
    end
  endtask

  // One clock: compare combinational outputs, clock the edge, compare statistics
  task automatic cyc();
    int   bi, hi;
    logic e_hit, e_misp;
    #1;
    bi     = bidx(lookup_pc);
    hi     = hidx(lookup_pc);
    e_hit  = (m_vld[bi] == 1) && (m_tag[bi] == tagof(lookup_pc));
    check("pred_hit", 32'(pred_hit), 32'(e_hit));
    check("pred_taken", 32'(pred_taken), 32'(e_hit && m_ctr[hi] >= 2));
    check("pred_target", pred_target, e_hit ? m_tgt[bi] : 32'h0);
    e_misp = upd_valid && ((upd_taken != upd_pred_taken) ||
                           (upd_taken && upd_target != upd_pred_target));
    check("mispredict", 32'(mispredict), 32'(e_misp));
    if (upd_valid)
      check("redirect_pc", redirect_pc, upd_taken ? upd_target : upd_pc + 32'd4);
    @(posedge clk);
    model_update(e_misp);
    @(negedge clk);
    check("perf_branches", perf_branches, m_pb);
    check("perf_mispredicts", perf_mispredicts, m_pm);
  endtask

  task automatic idle(input logic [31:0] lpc);
    rst = 1'b0; lookup_pc = lpc;
    upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_is_branch = 1'b0;
    upd_taken = 1'b0; upd_pred_taken = 1'b0; upd_pred_target = '0;
    init_we = 1'b0; init_idx = '0; init_btb = '0; init_bht = '0;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic br, input logic tk,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    upd_valid = 1'b1; upd_pc = pc; upd_is_branch = br; upd_taken = tk;
    upd_target = tgt; upd_pred_taken = ptk; upd_pred_target = ptgt;
  endtask

  logic [31:0] exp_pm, pm_base, measured;

  initial begin
    // Power-up reset; tables are unknown until this edge
    idle(32'h100);
    rst = 1'b1;
    @(posedge clk);
    model_update(1'b0);
    @(negedge clk);

    // Empty tables after reset
    idle(32'h100);
    #1;
    check("r34_hit", 32'(pred_hit), 32'h0);
    check("r34_taken", 32'(pred_taken), 32'h0);
    check("r34_target", pred_target, 32'h0);
    check("r34_perf_br", perf_branches, 32'h0);
    check("r34_perf_mp", perf_mispredicts, 32'h0);
    cyc();

    // Two taken updates allocate and saturate, a third holds
    idle(32'h100); set_upd(32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0); cyc();
    cyc();
    idle(32'h100);
    #1;
    check("r35_hit", 32'(pred_hit), 32'h1);
`ifndef BPU_GSHARE_EN
    check("r35_taken", 32'(pred_taken), 32'h1);
`endif
    check("r35_target", pred_target, 32'h200);
    cyc();
    set_upd(32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 32'h200); cyc();
    idle(32'h100); set_upd(32'h100, 1'b1, 1'b0, 32'h200, 1'b1, 32'h200); cyc();
    idle(32'h100);
    #1;
`ifndef BPU_GSHARE_EN
    check("r35_saturate", 32'(pred_taken), 32'h1);
`endif
    cyc();

    // Alias: same index, different tag
    idle(32'h100 + 32'(4 * ENT));
    #1;
    check("r36_alias_hit", 32'(pred_hit), 32'h0);
    cyc();

    // Predicted taken, actually not taken
    idle(32'h300); set_upd(32'h300, 1'b1, 1'b0, 32'h777, 1'b1, 32'h777);
    exp_pm = m_pm + 32'd1;
    #1;
    check("r37_mispredict", 32'(mispredict), 32'h1);
    check("r37_redirect", redirect_pc, 32'h304);
    cyc();
    check("r37_perf_mp", perf_mispredicts, exp_pm);

    // Preload and update on the same index: preload wins
    idle(32'h14); set_upd(32'h14, 1'b1, 1'b1, 32'h500, 1'b0, 32'h0);
    init_we = 1'b1; init_idx = 8'd5; init_btb = {1'b1, 8'h00, 32'h1234}; init_bht = 2'b00;
    cyc();
    idle(32'h14);
    #1;
    check("r38_same_hit", 32'(pred_hit), 32'h1);
    check("r38_same_target", pred_target, 32'h1234);
`ifndef BPU_GSHARE_EN
    check("r38_same_taken", 32'(pred_taken), 32'h0);
`endif
    cyc();

    // Preload and update on different indices: both land
    idle(32'h18); set_upd(32'h1C, 1'b1, 1'b1, 32'h3333, 1'b0, 32'h0);
    init_we = 1'b1; init_idx = 8'd6; init_btb = {1'b1, 8'h00, 32'h2222}; init_bht = 2'b11;
    cyc();
    idle(32'h18);
    #1;
    check("r38_diff_init_hit", 32'(pred_hit), 32'h1);
    check("r38_diff_init_target", pred_target, 32'h2222);
    cyc();
    idle(32'h1C);
    #1;
    check("r38_diff_upd_hit", 32'(pred_hit), 32'h1);
    check("r38_diff_upd_target", pred_target, 32'h3333);
    cyc();

    // Reset with an update in flight: update discarded, nothing hits
    idle(32'h1C); set_upd(32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
    rst = 1'b1;
    cyc();
    idle(32'h1C);
    #1;
    check("r29_hit_1c", 32'(pred_hit), 32'h0);
    check("r29_perf_br", perf_branches, 32'h0);
    cyc();
    idle(32'h100);
    #1;
    check("r29_hit_100", 32'(pred_hit), 32'h0);
    cyc();

    // Alternating T,N,T,N on one branch, predictions fed back from the lookup
    pm_base = '0;
    for (int n = 0; n < 24; n++) begin
      idle(32'h400);
      if (n == 12) pm_base = perf_mispredicts;
      set_upd(32'h400, 1'b1, (n % 2) == 0, 32'h800, 1'b0, 32'h0);
      #1;
      upd_pred_taken  = pred_taken;
      upd_pred_target = pred_target;
      cyc();
    end
    measured = perf_mispredicts - pm_base;
`ifdef BPU_GSHARE_EN
    check("r39_gshare_misp", measured, 32'h0);
`else
    check("r39_bimodal_misp", 32'(measured > 0), 32'h1);
`endif

    // Random traffic over a small index/tag pool so hits, aliases and collisions recur
    for (int n = 0; n < 600; n++) begin
      idle(({$urandom_range(0, 1)} << (2 + IDX_W)) | ({$urandom_range(0, 15)} << 2));
      rst = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 1) == 1) begin
        set_upd(({$urandom_range(0, 1)} << (2 + IDX_W)) | ({$urandom_range(0, 15)} << 2),
                $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                $urandom() & 32'hFFFF_FFFC, $urandom_range(0, 1) == 1, 32'h0);
        upd_pred_target = ($urandom_range(0, 1) == 1) ? upd_target : ($urandom() & 32'hFFFF_FFFC);
      end
      if ($urandom_range(0, 7) == 0) begin
        init_we  = 1'b1;
        init_idx = 8'($urandom_range(0, 15));
        init_btb = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFFC};
        init_bht = 2'($urandom_range(0, 3));
      end
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
